ccff_stream_loader: RTL and testbench
=====================================

Name: ccff_stream_loader

Overview:
- Configuration-chain loader that sits directly upstream of the fabric tile column.
- Accepts bitstream words over a valid/ready stream and serialises them MSB-first onto the chain head (ccff_head).
- Generates the per-bit shift enable for prog_clk gating and the config_enable window. The column's feedthrough tiles distribute config_enable onward.
- Reports busy and done to the SoC-side configuration controller.

Parameters:
- DATA_W, 32, stream word width in bits.
- CHAIN_LEN, 1024, total configuration bits in the chain (>=1).
- CNT_W, $clog2(CHAIN_LEN+1), width of the remaining-bit counter.

Ports:
- prog_clk  input  1  programming clock; all state on rising edge.
- pReset  input  1  synchronous, active-high reset.
- cfg_start  input  1  one-cycle pulse that starts a load; honoured only in IDLE.
- s_data  input  DATA_W  bitstream word; bit DATA_W-1 is shifted first.
- s_valid  input  1  s_data valid.
- s_ready  output  1  loader accepts s_data this cycle.
- ccff_head  output  1  serial configuration bit to the chain head.
- ccff_shift_en  output  1  chain shifts on this prog_clk edge; drives the clock gate.
- ccff_tail  input  1  chain tail return, used only with the optional feature.
- config_enable  output  1  configuration window to the fabric.
- busy  output  1  high from the cycle after cfg_start until done.
- done  output  1  one-cycle pulse at completion.
- tail_ones  output  16  ones counted on ccff_tail; 0 when the feature is compiled out.

Behaviour:
- Reset: pReset sampled high forces IDLE and clears every register.
  - All outputs are 0, including s_ready, ccff_head, ccff_shift_en, config_enable, busy, done and tail_ones.
  - Reset mid-load abandons the load with no done pulse.
  - pReset wins over a simultaneous cfg_start.
- State IDLE:
  - cfg_start=1 moves to ENABLE next cycle and loads remain=CHAIN_LEN.
  - cfg_start is ignored in every other state.
- State ENABLE (exactly 1 cycle): config_enable=1, busy=1, s_ready=0, ccff_shift_en=0. This is the setup cycle. Next state is SHIFT.
- State SHIFT:
  - config_enable=1 and busy=1.
  - Internal shift register sreg and word-bit count wbits.
  - s_ready=1 when (wbits==0 or wbits==1) and (remain - wbits) > 0.
  - On accept (s_valid & s_ready): sreg <= s_data and wbits <= min(DATA_W, remain - wbits_after_this_cycle).
  - The wbits==1 accept gives back-to-back streaming with no bubble.
  - ccff_head = sreg[DATA_W-1]; ccff_shift_en = (wbits != 0).
  - Each cycle with shift_en=1: sreg shifts left by 1, wbits decrements, remain decrements.
  - Underflow (wbits==0, no valid word): ccff_shift_en=0 and ccff_head holds its last value. This is a stall, not an error.
  - Last word partial (CHAIN_LEN not a multiple of DATA_W): only the top remain bits are shifted; the low bits are discarded.
  - When remain reaches 0: s_ready=0, surplus words are not accepted, and the next state is DRAIN.
- State DRAIN (1 cycle): config_enable=1, ccff_shift_en=0. Next state is DONE.
- State DONE (1 cycle): config_enable=0, busy=0, done=1. Next state is IDLE.
- Latency: with a continuous stream, cfg_start at cycle t gives the first shift_en at t+3 and done at t+3+CHAIN_LEN+1.
- Width rule: remain uses CNT_W bits and never wraps below 0.

Optional Feature:
- Macro: CCFF_TAIL_COUNT_EN.
- When defined:
  - tail_ones increments by 1 on each cycle with ccff_shift_en=1 and ccff_tail=1.
  - It saturates at 16'hFFFF and clears on cfg_start accept and on pReset.
  - It is held stable after done for software readback of the previous chain contents.
- When not defined: tail_ones is tied to 0, ccff_tail is unused, and no counter logic is present.

Test Plan:
- DATA_W=8, CHAIN_LEN=20, words 0xA5,0x3C,0xF0 streamed continuously:
  - ccff_head sequence is 1010_0101_0011_1100_1111.
  - Exactly 20 shift_en cycles, no gaps; 0xF0 low nibble discarded.
  - done at cfg_start+24.
- Same configuration with s_valid dropped for 3 cycles after the first word: shift_en low for exactly those stall cycles, ccff_head holds, total still 20, done delayed by 3.
- After the third word is accepted, s_valid held high with a 4th word: s_ready stays 0, the word is never consumed, and config_enable falls the cycle after DRAIN.
- pReset asserted at shift bit 7: all outputs 0 next cycle, no done pulse; a new cfg_start then performs a complete clean 20-bit load.
- cfg_start pulsed during SHIFT: ignored, and the bit count is unaffected. cfg_start together with pReset: stays in IDLE.
- With CCFF_TAIL_COUNT_EN, ccff_tail driven with pattern 0xFFFFF during a 20-bit load: tail_ones=20 after done. Compiled out: tail_ones=0 throughout.

Source files
------------

// File: rtl/ccff_stream_loader.sv
// ccff_stream_loader: streams bitstream words MSB-first onto the config chain head with shift enable and config window.
// Optional CCFF_TAIL_COUNT_EN counts ones returned on ccff_tail into tail_ones.
module ccff_stream_loader #(
    parameter int DATA_W    = 32,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              cfg_start,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              config_enable,
    output logic              busy,
    output logic              done,
    output logic [15:0]       tail_ones
);
    localparam int WB_W = $clog2(DATA_W + 1);
    typedef enum logic [2:0] {IDLE, ENABLE, SHIFT, DRAIN, DONE} state_t;
    state_t            state;
    logic [DATA_W-1:0] sreg;
    logic [WB_W-1:0]   wbits, wb_load;
    logic [CNT_W-1:0]  remain, remain_nx;
    logic              shift_en, accept;
    always_comb begin
        shift_en  = (state == SHIFT) && (wbits != '0);
        s_ready   = (state == SHIFT) && (32'(wbits) <= 32'd1) && (32'(remain) > 32'(wbits));
        accept    = s_valid && s_ready;
        remain_nx = remain - CNT_W'(shift_en);
        wb_load   = (32'(remain_nx) < 32'(DATA_W)) ? WB_W'(remain_nx) : WB_W'(DATA_W);
    end
    assign ccff_head     = sreg[DATA_W-1];
    assign ccff_shift_en = shift_en;
    assign config_enable = (state == ENABLE) || (state == SHIFT) || (state == DRAIN);
    assign busy          = config_enable;
    assign done          = (state == DONE);
    // The last bit of a word is not shifted out of sreg so ccff_head holds it through a stall.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state  <= IDLE;
            sreg   <= '0;
            wbits  <= '0;
            remain <= '0;
        end else begin
            case (state)
                IDLE: if (cfg_start) begin
                    state  <= ENABLE;
                    remain <= CNT_W'(CHAIN_LEN);
                    wbits  <= '0;
                end
                ENABLE: state <= SHIFT;
                SHIFT: begin
                    remain <= remain_nx;
                    wbits  <= accept ? wb_load : wbits - WB_W'(shift_en);
                    sreg   <= accept ? s_data : (shift_en && wbits != WB_W'(1)) ? sreg << 1 : sreg;
                    if (remain_nx == '0) state <= DRAIN;
                end
                DRAIN: state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
`ifdef CCFF_TAIL_COUNT_EN
    always_ff @(posedge prog_clk) begin
        if (pReset || (state == IDLE && cfg_start)) tail_ones <= '0;
        else if (shift_en && ccff_tail && tail_ones != 16'hFFFF) tail_ones <= tail_ones + 16'd1;
    end
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign tail_ones   = '0;
`endif
endmodule

// File: tb/tb_ccff_stream_loader.sv
// tb_ccff_stream_loader: directed and randomized loads of a 20-bit chain fed by 8-bit words.
module tb_ccff_stream_loader;
    localparam int DW = 8;
    localparam int CL = 20;
    logic          prog_clk = 1'b0;
    logic          pReset = 1'b1, cfg_start = 1'b0, s_valid = 1'b0, ccff_tail = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready, ccff_head, ccff_shift_en, config_enable, busy, done;
    logic [15:0]   tail_ones;
    int            vectors = 0, fails = 0;

    ccff_stream_loader #(.DATA_W(DW), .CHAIN_LEN(CL)) dut (
        .prog_clk(prog_clk), .pReset(pReset), .cfg_start(cfg_start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
        .config_enable(config_enable), .busy(busy), .done(done), .tail_ones(tail_ones)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    function automatic logic [31:0] tail_expect(input int n);
`ifdef CCFF_TAIL_COUNT_EN
        return (n > 65535) ? 32'hFFFF : 32'(n);
`else
        return 32'(n) & 32'h0;
`endif
    endfunction

    // mode 0: continuous, 1: three-cycle stall at the first word boundary, 2: random valid
    // tail_mode 0: tail low, 1: tail high, 2: random tail
    task automatic run_load(input string tag, input int mode, input int rst_bit, input bit poke,
                            input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                            input logic [7:0] w3, input int tail_mode);
        logic [7:0] w[4];
        logic       exp_bits[CL];
        logic       last_head;
        int idx, shifts, cyc, first, last, done_cyc, dones, drop, gaps, exp_tail, bad_bits, bad_hold, ce_bad;
        bit rst_hit, want;
        w = '{w0, w1, w2, w3};
        for (int i = 0; i < CL; i++) exp_bits[i] = w[i / 8][7 - (i % 8)];
        idx = 0; shifts = 0; first = -1; last = -1; done_cyc = -1; dones = 0; drop = 0;
        gaps = 0; exp_tail = 0; bad_bits = 0; bad_hold = 0; ce_bad = 0; rst_hit = 0; last_head = 1'b0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cyc = 1;
        while (cyc < 200) begin
            ccff_tail = (tail_mode == 1) ? 1'b1 : (tail_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (ccff_shift_en) begin
                if (first < 0) first = cyc;
                last = cyc;
                if (shifts >= CL || ccff_head !== exp_bits[shifts]) bad_bits++;
                if (ccff_tail) exp_tail++;
                shifts++;
                last_head = ccff_head;
                if (shifts == rst_bit) begin
                    rst_hit = 1;
                    break;
                end
            end else if (first >= 0 && config_enable && shifts < CL) begin
                gaps++;
                if (ccff_head !== last_head) bad_hold++;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
                check({tag, " cfg_en at done"}, {config_enable, busy}, 0);
            end else if (done_cyc < 0 && !config_enable) ce_bad++;
            want = (idx < 4);
            if (mode == 1 && idx == 1 && s_ready && drop < 3) begin
                want = 0;
                drop++;
            end
            if (mode == 2 && $urandom_range(0, 2) == 0) want = 0;
            s_valid = want;
            s_data = w[(idx < 4) ? idx : 3];
            if (want && s_ready) idx++;
            cfg_start = (poke && cyc == 10);
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            tick();
            cyc++;
        end
        cfg_start = 1'b0;
        if (rst_hit) begin
            pReset = 1'b1;
            s_valid = 1'b0;
            tick();
            check({tag, " reset outputs"}, {s_ready, ccff_head, ccff_shift_en, config_enable, busy, done, tail_ones}, 0);
            pReset = 1'b0;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (done || config_enable) ce_bad++;
            end
            check({tag, " no done after reset"}, ce_bad, 0);
        end else begin
            s_valid = 1'b0;
            check({tag, " shift count"}, shifts, CL);
            check({tag, " head bits"}, bad_bits, 0);
            check({tag, " done pulses"}, dones, 1);
            check({tag, " words accepted"}, idx, 3);
            check({tag, " head hold"}, bad_hold, 0);
            check({tag, " cfg_en window"}, ce_bad, 0);
            check({tag, " done after last shift"}, done_cyc, last + 2);
            if (mode != 2) begin
                check({tag, " first shift"}, first, 3);
                check({tag, " stall gaps"}, gaps, (mode == 1) ? 3 : 0);
                check({tag, " done cycle"}, done_cyc, (mode == 1) ? 27 : 24);
            end
            check({tag, " idle after"}, {s_ready, ccff_shift_en, config_enable, busy, done}, 0);
            check({tag, " tail_ones"}, 32'(tail_ones), tail_expect(exp_tail));
        end
    endtask

    initial begin
        tick();
        tick();
        check("reset state", {s_ready, ccff_head, ccff_shift_en, config_enable, busy, done, tail_ones}, 0);
        pReset = 1'b0;
        tick();
        run_load("continuous", 0, 0, 0, 8'hA5, 8'h3C, 8'hF0, 8'h5A, 1);
        run_load("stall", 1, 0, 0, 8'hA5, 8'h3C, 8'hF0, 8'h5A, 0);
        run_load("reset mid", 0, 7, 0, 8'hA5, 8'h3C, 8'hF0, 8'h5A, 1);
        run_load("after reset", 0, 0, 0, 8'hA5, 8'h3C, 8'hF0, 8'h5A, 2);
        run_load("start poke", 0, 0, 1, 8'h96, 8'h0F, 8'hC3, 8'hFF, 1);
        pReset = 1'b1;
        cfg_start = 1'b1;
        tick();
        pReset = 1'b0;
        cfg_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("start with reset", {config_enable, busy, s_ready, done}, 0);
        end
        for (int r = 0; r < 6; r++)
            run_load("random", 2, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2);
        run_load("final continuous", 0, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
